// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone 2:1 arbiter.
package wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam logic [31:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Watchdog counter width: enough to hold the limit, kept within 8..16 bits.
    function automatic int wb_cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 8) w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/wb_rr_pick2.sv
// Combinational two-way round-robin picker: one-hot grant for the requester
// that did not own the bus last when both request at once.
module wb_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_owner ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Round-robin arbiter sharing one Wishbone slave between two masters.
// Define WB_ARB_TIMEOUT_EN to add the stalled-slave watchdog and timeout_flag.
module wb_arbiter_2to1
    import wb_pkg::*;
#(
    parameter int ADDR_W         = WB_ADDR_W,
    parameter int DATA_W         = WB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_cycle,
    input  logic                m0_strobe,
    input  logic                m0_write_enable,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W-1:0]   m0_data_in,
    input  logic [DATA_W/8-1:0] m0_select,
    output logic                m0_ack,
    output logic [DATA_W-1:0]   m0_data_out,
    input  logic                m1_cycle,
    input  logic                m1_strobe,
    input  logic                m1_write_enable,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W-1:0]   m1_data_in,
    input  logic [DATA_W/8-1:0] m1_select,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m1_data_out,
    output logic                s_cycle,
    output logic                s_strobe,
    output logic                s_write_enable,
    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W-1:0]   s_data_in,
    output logic [DATA_W/8-1:0] s_select,
    input  logic                s_ack,
    input  logic [DATA_W-1:0]   s_data_out,
`ifdef WB_ARB_TIMEOUT_EN
    output logic                timeout_flag,
`endif
    output logic [1:0]          grant
);

    // Handshake: a master holds cycle and strobe until it sees ack; a transfer
    // completes on the clock edge where the owner's strobe and ack are both high.

    arb_state_t state;
    logic       last_owner;
    logic [1:0] pick;
    logic       own0;
    logic       own1;
    logic       timeout_hit;

    wb_rr_pick2 u_pick (
        .req        ({m1_cycle, m0_cycle}),
        .last_owner (last_owner),
        .gnt        (pick)
    );

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            grant      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (pick[0]) begin
                        state      <= OWN0;
                        last_owner <= 1'b0;
                        grant      <= 2'b01;
                    end else if (pick[1]) begin
                        state      <= OWN1;
                        last_owner <= 1'b1;
                        grant      <= 2'b10;
                    end
                end
                OWN0: begin
                    if (!m0_cycle) begin
                        if (m1_cycle) begin
                            state      <= OWN1;
                            last_owner <= 1'b1;
                            grant      <= 2'b10;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                OWN1: begin
                    if (!m1_cycle) begin
                        if (m0_cycle) begin
                            state      <= OWN0;
                            last_owner <= 1'b0;
                            grant      <= 2'b01;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = wb_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             owner_cyc;
    logic             owner_stb;

    assign owner_cyc   = (own0 & m0_cycle) | (own1 & m1_cycle);
    assign owner_stb   = owner_cyc & ((own0 & m0_strobe) | (own1 & m1_strobe));
    assign timeout_hit = owner_stb & ~s_ack & (wd_cnt == CNT_LAST);

    // Every grant entry is preceded by a cycle with no owner cycle, so clearing
    // on that condition restarts the count for each new tenure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (timeout_hit) timeout_flag <= 1'b1;
            if (!owner_cyc || s_ack || timeout_hit) wd_cnt <= '0;
            else if (owner_stb) wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        s_cycle        = 1'b0;
        s_strobe       = 1'b0;
        s_write_enable = 1'b0;
        s_address      = '0;
        s_data_in      = '0;
        s_select       = '0;
        if (own0) begin
            s_cycle        = m0_cycle & ~timeout_hit;
            s_strobe       = m0_strobe & ~timeout_hit;
            s_write_enable = m0_write_enable;
            s_address      = m0_address;
            s_data_in      = m0_data_in;
            s_select       = m0_select;
        end else if (own1) begin
            s_cycle        = m1_cycle & ~timeout_hit;
            s_strobe       = m1_strobe & ~timeout_hit;
            s_write_enable = m1_write_enable;
            s_address      = m1_address;
            s_data_in      = m1_data_in;
            s_select       = m1_select;
        end
    end

    always_comb begin
        m0_ack      = own0 & (s_ack | timeout_hit);
        m1_ack      = own1 & (s_ack | timeout_hit);
        m0_data_out = '0;
        m1_data_out = '0;
        if (own0) m0_data_out = timeout_hit ? DATA_W'(WB_TIMEOUT_DATA) : s_data_out;
        if (own1) m1_data_out = timeout_hit ? DATA_W'(WB_TIMEOUT_DATA) : s_data_out;
    end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Self-checking bench for wb_arbiter_2to1: slave model, per-master expected
// queues popped on ack, and a reference memory for read data.
module tb_wb_arbiter_2to1;

    logic        clk;
    logic        rst;
    logic        m0_cycle, m0_strobe, m0_write_enable;
    logic [31:0] m0_address, m0_data_in;
    logic [3:0]  m0_select;
    logic        m0_ack;
    logic [31:0] m0_data_out;
    logic        m1_cycle, m1_strobe, m1_write_enable;
    logic [31:0] m1_address, m1_data_in;
    logic [3:0]  m1_select;
    logic        m1_ack;
    logic [31:0] m1_data_out;
    logic        s_cycle, s_strobe, s_write_enable;
    logic [31:0] s_address, s_data_in;
    logic [3:0]  s_select;
    logic        s_ack;
    logic [31:0] s_data_out;
    logic [1:0]  grant;
`ifdef WB_ARB_TIMEOUT_EN
    logic        timeout_flag;
`endif

    wb_arbiter_2to1 #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_cycle(m0_cycle), .m0_strobe(m0_strobe), .m0_write_enable(m0_write_enable),
        .m0_address(m0_address), .m0_data_in(m0_data_in), .m0_select(m0_select),
        .m0_ack(m0_ack), .m0_data_out(m0_data_out),
        .m1_cycle(m1_cycle), .m1_strobe(m1_strobe), .m1_write_enable(m1_write_enable),
        .m1_address(m1_address), .m1_data_in(m1_data_in), .m1_select(m1_select),
        .m1_ack(m1_ack), .m1_data_out(m1_data_out),
        .s_cycle(s_cycle), .s_strobe(s_strobe), .s_write_enable(s_write_enable),
        .s_address(s_address), .s_data_in(s_data_in), .s_select(s_select),
        .s_ack(s_ack), .s_data_out(s_data_out),
`ifdef WB_ARB_TIMEOUT_EN
        .timeout_flag(timeout_flag),
`endif
        .grant(grant)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp0_q[$];
    exp_t        exp1_q[$];
    logic [1:0]  ten_q[$];
    logic [1:0]  g_hist[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] slv_mem[logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          ack_cnt0 = 0;
    int          ack_cnt1 = 0;
    logic [1:0]  prev_grant = 2'b00;

    int          slv_lat = 0;
    bit          slv_stall = 0;
    bit          slv_rand = 0;

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : mem_default(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    int          wcnt;
    bit          pend, pend_we;
    logic [31:0] pend_a, pend_d;

    initial begin
        s_ack = 1'b0;
        s_data_out = '0;
        wcnt = 0;
        pend = 0;
        pend_we = 0;
        pend_a = '0;
        pend_d = '0;
        forever begin
            @(posedge clk);
            #2;
            if (s_ack) begin
                if (pend && pend_we) slv_mem[pend_a] = pend_d;
                pend = 0;
                s_ack = 1'b0;
                s_data_out = '0;
                wcnt = 0;
                if (slv_rand) slv_lat = $urandom_range(0, 3);
            end else if (s_cycle && s_strobe && !slv_stall) begin
                if (wcnt >= slv_lat) begin
                    s_ack = 1'b1;
                    pend = 1;
                    pend_we = s_write_enable;
                    pend_a = s_address;
                    pend_d = s_data_in;
                    s_data_out = s_write_enable ? 32'h0 : slv_rd(s_address);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                logic ok;
                logic to0, to1;
                exp_t e;
                to0 = m0_ack && !s_ack;
                to1 = m1_ack && !s_ack;
                ok = 1'b1;
                case (grant)
                    2'b00: ok = !s_cycle && !s_strobe && !s_write_enable && s_address == 0 &&
                                s_data_in == 0 && s_select == 0 && !m0_ack && !m1_ack &&
                                m0_data_out == 0 && m1_data_out == 0;
                    2'b01: ok = !m1_ack && m1_data_out == 0 && s_address == m0_address &&
                                s_data_in == m0_data_in && s_select == m0_select &&
                                s_write_enable == m0_write_enable &&
                                (to0 ? (!s_cycle && !s_strobe)
                                     : (s_cycle == m0_cycle && s_strobe == m0_strobe));
                    2'b10: ok = !m0_ack && m0_data_out == 0 && s_address == m1_address &&
                                s_data_in == m1_data_in && s_select == m1_select &&
                                s_write_enable == m1_write_enable &&
                                (to1 ? (!s_cycle && !s_strobe)
                                     : (s_cycle == m1_cycle && s_strobe == m1_strobe));
                    default: ok = 1'b0;
                endcase
                check($sformatf("isolation_g%0b", grant), 64'(ok), 64'(1'b1));

                if (m0_ack) begin
                    ack_cnt0++;
                    if (exp0_q.size() == 0) check("m0_unexpected_ack", 64'(1), 64'(0));
                    else begin
                        e = exp0_q.pop_front();
                        check("m0_addr", 64'(s_address), 64'(e.addr));
                        if (e.we) check("m0_wdata", 64'(s_data_in), 64'(e.data));
                        else      check("m0_rdata", 64'(m0_data_out), 64'(e.data));
                    end
                end
                if (m1_ack) begin
                    ack_cnt1++;
                    if (exp1_q.size() == 0) check("m1_unexpected_ack", 64'(1), 64'(0));
                    else begin
                        e = exp1_q.pop_front();
                        check("m1_addr", 64'(s_address), 64'(e.addr));
                        if (e.we) check("m1_wdata", 64'(s_data_in), 64'(e.data));
                        else      check("m1_rdata", 64'(m1_data_out), 64'(e.data));
                    end
                end

                g_hist.push_back(grant);
                if (grant != prev_grant && grant != 2'b00) ten_q.push_back(grant);
            end
            prev_grant = rst ? 2'b00 : grant;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        if (m == 0) begin
            m0_cycle = cyc; m0_strobe = stb; m0_write_enable = we;
            m0_address = a; m0_data_in = d; m0_select = sel;
        end else begin
            m1_cycle = cyc; m1_strobe = stb; m1_write_enable = we;
            m1_address = a; m1_data_in = d; m1_select = sel;
        end
    endtask

    // One classic Wishbone transfer; call aligned just after a rising edge.
    task automatic xfer(input int m, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input bit tmo);
        exp_t e;
        bit   got;
        e.we   = we;
        e.addr = a;
        e.data = we ? d : (tmo ? 32'hDEAD_BEEF : ref_rd(a));
        if (we) ref_mem[a] = d;
        if (m == 0) exp0_q.push_back(e);
        else        exp1_q.push_back(e);
        drive(m, 1'b1, 1'b1, we, a, d, 4'hF);
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack : m1_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) check($sformatf("m%0d_ack_wait", m), 64'(0), 64'(1));
        @(posedge clk);
        #1;
        drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        ten_q.delete();
        g_hist.delete();
        step(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b0, b1, owned;
        bit found;
        logic [1:0] exp_seq[6];
        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

        // reset state
        @(negedge clk);
        check("rst_grant", 64'(grant), 64'(2'b00));
        check("rst_s_ctrl", 64'({s_cycle, s_strobe, s_write_enable}), 64'(3'b000));
        check("rst_s_addr", 64'(s_address), 64'(0));
        check("rst_m_ack", 64'({m0_ack, m1_ack}), 64'(2'b00));
        check("rst_m_data", 64'({m0_data_out, m1_data_out}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);

        // stray slave ack while idle
        #2;
        s_ack = 1'b1;
        s_data_out = 32'hFFFF_FFFF;
        @(negedge clk);
        check("idle_ack_ignored", 64'({m0_ack, m1_ack}), 64'(2'b00));
        check("idle_data_zero", 64'({m0_data_out, m1_data_out}), 64'(0));
        step(2);

        // single master write, slave acks 2 cycles after strobe
        slv_lat = 2;
        b0 = ack_cnt0;
        b1 = ack_cnt1;
        ten_q.delete();
        fork
            xfer(0, 1'b1, 32'h100, 32'h1234_5678, 1'b0);
            begin
                @(negedge clk);
                check("lat_pre_grant", 64'(grant), 64'(2'b00));
                check("lat_pre_scyc", 64'(s_cycle), 64'(0));
                @(negedge clk);
                check("lat_grant", 64'(grant), 64'(2'b01));
                check("lat_s_addr", 64'(s_address), 64'(32'h100));
                check("lat_s_wdata", 64'(s_data_in), 64'(32'h1234_5678));
            end
        join
        step(2);
        check("single_idle_after", 64'(grant), 64'(2'b00));
        check("single_m0_acks", 64'(ack_cnt0 - b0), 64'(1));
        check("single_m1_acks", 64'(ack_cnt1 - b1), 64'(0));
        check("single_tenures", 64'(ten_q.size()), 64'(1));
        xfer(0, 1'b0, 32'h100, 32'h0, 1'b0);
        step(1);

        // tie after reset: m0 first, direct handoff to m1
        do_reset();
        slv_lat = 1;
        fork
            xfer(0, 1'b0, 32'h104, 32'h0, 1'b0);
            xfer(1, 1'b0, 32'h2000, 32'h0, 1'b0);
        join
        step(2);
        check("tie_count", 64'(ten_q.size()), 64'(2));
        if (ten_q.size() >= 2) begin
            check("tie_first", 64'(ten_q[0]), 64'(2'b01));
            check("tie_second", 64'(ten_q[1]), 64'(2'b10));
        end
        found = 0;
        for (int i = 0; i + 1 < g_hist.size(); i++)
            if (g_hist[i] == 2'b01 && g_hist[i+1] == 2'b10) found = 1;
        check("tie_no_bubble", 64'(found), 64'(1));

        // fairness: back-to-back reads alternate
        do_reset();
        slv_lat = 1;
        b0 = ack_cnt0;
        b1 = ack_cnt1;
        fork
            for (int i = 0; i < 3; i++) begin
                xfer(0, 1'b0, 32'h200 + 32'(i * 4), 32'h0, 1'b0);
                step(1);
            end
            for (int i = 0; i < 3; i++) begin
                xfer(1, 1'b0, 32'h300 + 32'(i * 4), 32'h0, 1'b0);
                step(1);
            end
        join
        step(2);
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        check("fair_count", 64'(ten_q.size()), 64'(6));
        for (int i = 0; i < 6 && i < ten_q.size(); i++)
            check($sformatf("fair_tenure%0d", i), 64'(ten_q[i]), 64'(exp_seq[i]));
        check("fair_m0_acks", 64'(ack_cnt0 - b0), 64'(3));
        check("fair_m1_acks", 64'(ack_cnt1 - b1), 64'(3));

        // isolation: m1 wiggles without cycle while m0 owns
        do_reset();
        slv_lat = 3;
        b1 = ack_cnt1;
        fork
            xfer(0, 1'b1, 32'h140, 32'hCAFE_0001, 1'b0);
            begin
                for (int i = 0; i < 8; i++) begin
                    m1_strobe       = 1'($urandom_range(0, 1));
                    m1_write_enable = 1'($urandom_range(0, 1));
                    m1_address      = $urandom;
                    m1_data_in      = $urandom;
                    m1_select       = 4'($urandom_range(0, 15));
                    step(1);
                end
                drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
            end
        join
        step(2);
        check("iso_m1_acks", 64'(ack_cnt1 - b1), 64'(0));

        // reset during an m1 transfer stalled by the slave
        do_reset();
        slv_stall = 1;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h2040, 32'h0, 4'hF);
        step(3);
        check("rmid_owned", 64'(grant), 64'(2'b10));
        check("rmid_scyc_before", 64'(s_cycle), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rmid_scyc_async", 64'(s_cycle), 64'(0));
        check("rmid_grant_async", 64'(grant), 64'(2'b00));
        check("rmid_ack", 64'(m1_ack), 64'(0));
        drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        step(2);
        rst = 1'b0;
        slv_stall = 0;
        ten_q.delete();
        step(1);
        fork
            xfer(0, 1'b0, 32'h108, 32'h0, 1'b0);
            xfer(1, 1'b0, 32'h2044, 32'h0, 1'b0);
        join
        step(2);
        check("rmid_tie_count", 64'(ten_q.size()), 64'(2));
        if (ten_q.size() >= 1) check("rmid_tie_m0", 64'(ten_q[0]), 64'(2'b01));

`ifdef WB_ARB_TIMEOUT_EN
        // watchdog: slave never acks m0
        do_reset();
        check("to_flag_reset", 64'(timeout_flag), 64'(0));
        slv_stall = 1;
        owned = 0;
        fork
            xfer(0, 1'b0, 32'h180, 32'h0, 1'b1);
            begin
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    if (grant == 2'b01) owned++;
                    if (m0_ack) break;
                end
                check("to_ack_cycle", 64'(owned), 64'(8));
            end
        join
        slv_stall = 0;
        step(1);
        check("to_flag_set", 64'(timeout_flag), 64'(1));
        ten_q.delete();
        xfer(1, 1'b0, 32'h2080, 32'h0, 1'b0);
        step(2);
        check("to_m1_granted", 64'(ten_q.size()), 64'(1));
        check("to_flag_sticky", 64'(timeout_flag), 64'(1));
`endif

        // randomized traffic from both masters
        do_reset();
        slv_rand = 1;
        slv_lat = 1;
        b0 = ack_cnt0;
        b1 = ack_cnt1;
        fork
            for (int i = 0; i < 40; i++) begin
                xfer(0, 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 7) * 4),
                     $urandom, 1'b0);
                step($urandom_range(0, 3));
            end
            for (int i = 0; i < 40; i++) begin
                xfer(1, 1'($urandom_range(0, 1)), 32'h2100 + 32'($urandom_range(0, 7) * 4),
                     $urandom, 1'b0);
                step($urandom_range(0, 3));
            end
        join
        step(4);
        check("rand_m0_acks", 64'(ack_cnt0 - b0), 64'(40));
        check("rand_m1_acks", 64'(ack_cnt1 - b1), 64'(40));
        check("exp0_drained", 64'(exp0_q.size()), 64'(0));
        check("exp1_drained", 64'(exp1_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global time bound
    initial begin
        #500000;
        check("global_timeout", 64'(0), 64'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
